// File: rtl/ro_puf_response_ctrl.sv
// rtl/ro_puf_response_ctrl.sv - RO PUF challenge/response sequencer with synchronized edge counting
module ro_puf_response_ctrl #(
    parameter int RESP_BITS     = 8,
    parameter int CNT_W         = 12,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [5:0]           i_challenge,
    input  logic                 i_ro_a,
    input  logic                 i_ro_b,
    output logic [2:0]           o_sel_a,
    output logic [2:0]           o_sel_b,
    output logic                 o_busy,
    output logic                 o_resp_valid,
    output logic [RESP_BITS-1:0] o_response,
    output logic [4:0]           o_tie_cnt,
    output logic                 o_sat_flag
);
    localparam int IDX_W   = $clog2(RESP_BITS);
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic [1:0]       r_sync_a;
    logic [1:0]       r_sync_b;
    logic             r_edge_a;
    logic             r_edge_b;
    logic             w_rise_a;
    logic             w_rise_b;
    logic [2:0]       w_off;

    assign w_rise_a = r_sync_a[1] & ~r_edge_a;
    assign w_rise_b = r_sync_b[1] & ~r_edge_b;
    // A zero pair offset would select the same oscillator twice, so it maps to the opposite ring.
    assign w_off    = (i_challenge[5:3] == 3'd0) ? 3'd4 : i_challenge[5:3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_edge_a <= 1'b0;
            r_edge_b <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[0], i_ro_a};
            r_sync_b <= {r_sync_b[0], i_ro_b};
            r_edge_a <= r_sync_a[1];
            r_edge_b <= r_sync_b[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_idx        <= '0;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            o_sel_a      <= '0;
            o_sel_b      <= '0;
            o_busy       <= 1'b0;
            o_resp_valid <= 1'b0;
            o_response   <= '0;
            o_tie_cnt    <= '0;
            o_sat_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    if (i_start) begin
                        o_sel_a      <= i_challenge[2:0];
                        o_sel_b      <= i_challenge[2:0] + w_off;
                        r_idx        <= '0;
                        o_response   <= '0;
                        o_tie_cnt    <= '0;
                        o_sat_flag   <= 1'b0;
                        o_resp_valid <= 1'b0;
                        o_busy       <= 1'b1;
                        r_tmr        <= TMR_W'(SETTLE_CYCLES - 1);
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    if (r_tmr == '0) begin
                        r_tmr   <= TMR_W'(WINDOW_CYCLES - 1);
                        r_state <= S_COUNT;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_COUNT: begin
                    if (w_rise_a && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
                    if (w_rise_b && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
                    if (r_tmr == '0) r_state <= S_COMPARE;
                    else             r_tmr   <= r_tmr - TMR_W'(1);
                end
                S_COMPARE: begin
                    o_response[r_idx] <= (r_cnt_a > r_cnt_b);
                    if (r_cnt_a == r_cnt_b) o_tie_cnt <= o_tie_cnt + 5'd1;
                    if ((r_cnt_a == CNT_MAX) || (r_cnt_b == CNT_MAX)) o_sat_flag <= 1'b1;
                    if (r_idx == IDX_W'(RESP_BITS - 1)) begin
                        o_busy       <= 1'b0;
                        o_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        // sel_b tracks sel_a at a fixed offset, so both simply step together.
                        r_idx   <= r_idx + IDX_W'(1);
                        o_sel_a <= o_sel_a + 3'd1;
                        o_sel_b <= o_sel_b + 3'd1;
                        r_tmr   <= TMR_W'(SETTLE_CYCLES - 1);
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ro_puf_response_ctrl.sv
// tb/tb_ro_puf_response_ctrl.sv - table-driven and randomized bench for ro_puf_response_ctrl
module tb_ro_puf_response_ctrl;
    localparam int RB  = 4;
    localparam int W   = 8;
    localparam int S   = 2;
    localparam int P   = S + W + 1;
    localparam int LAT = RB * P;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic [5:0]    challenge = '0;
    logic          ro_a      = 1'b0;
    logic          ro_b      = 1'b0;
    logic [2:0]    sel_a, sel_b, sel_a2, sel_b2;
    logic          busy, busy2, valid, valid2, sat, sat2;
    logic [RB-1:0] resp, resp2;
    logic [4:0]    tie, tie2;

    int total = 0;
    int bad   = 0;
    // va[j+1]/vb[j+1] hold the oscillator level driven during cycle j after the accepting edge
    logic va [0:63];
    logic vb [0:63];
    logic          prev_valid = 1'b0;
    logic [RB-1:0] prev_resp  = '0;

    typedef struct {
        logic [5:0]    ch;
        int            pa, pha, la, pb, phb, lb;
        logic [RB-1:0] resp;
        int            tie;
        logic          sat1, sat2;
        int            bsk;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    ro_puf_response_ctrl #(.RESP_BITS(RB), .CNT_W(8), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_challenge(challenge),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_busy(busy),
        .o_resp_valid(valid), .o_response(resp), .o_tie_cnt(tie), .o_sat_flag(sat));

    ro_puf_response_ctrl #(.RESP_BITS(RB), .CNT_W(2), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_challenge(challenge),
        .i_ro_a(ro_a), .i_ro_b(ro_b), .o_sel_a(sel_a2), .o_sel_b(sel_b2), .o_busy(busy2),
        .o_resp_valid(valid2), .o_response(resp2), .o_tie_cnt(tie2), .o_sat_flag(sat2));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic wave_bit(input int p, input int ph, input int lvl, input int k);
        if (p == 0) return lvl[0];
        return ((k + ph + 8 * p) % p) < (p / 2);
    endfunction

    task automatic fill_periodic(input int pa, input int pha, input int la,
                                 input int pb, input int phb, input int lb);
        for (int i = 0; i < 64; i++) begin
            va[i] = wave_bit(pa, pha, la, i - 1);
            vb[i] = wave_bit(pb, phb, lb, i - 1);
        end
    endtask

    // Rising edges seen in the bit-b window; synchronizer plus edge flop delays each sample by 2 cycles.
    function automatic int win_edges(input logic use_b, input int b);
        int n;
        n = 0;
        for (int k = b * P + S; k < b * P + S + W; k++) begin
            logic cur, prv;
            cur = use_b ? vb[k - 1] : va[k - 1];
            prv = use_b ? vb[k - 2] : va[k - 2];
            if (cur && !prv) n++;
        end
        return n;
    endfunction

    task automatic model(input int maxc, output logic [RB-1:0] r, output int t, output logic s);
        r = '0;
        t = 0;
        s = 1'b0;
        for (int b = 0; b < RB; b++) begin
            int ca, cb;
            ca = win_edges(1'b0, b);
            cb = win_edges(1'b1, b);
            if (ca > maxc) ca = maxc;
            if (cb > maxc) cb = maxc;
            r[b] = (ca > cb);
            if (ca == cb) t++;
            if (ca == maxc || cb == maxc) s = 1'b1;
        end
    endtask

    task automatic run_eval(input logic [5:0] ch, input int bsk, input int abort_k, input logic use_tbl,
                            input logic [RB-1:0] t_resp, input int t_tie, input logic t_sat1,
                            input logic t_sat2, input string tag);
        logic [RB-1:0] e_resp, e_resp2;
        int            e_tie, e_tie2, ea, eb, off;
        logic          e_sat, e_sat2;
        model(255, e_resp, e_tie, e_sat);
        model(3, e_resp2, e_tie2, e_sat2);
        if (use_tbl) begin
            e_resp = t_resp; e_tie = t_tie; e_sat = t_sat1;
            e_resp2 = t_resp; e_tie2 = t_tie; e_sat2 = t_sat2;
        end
        off = (ch[5:3] == 3'd0) ? 4 : int'(ch[5:3]);
        @(negedge clk);
        if (prev_valid) begin
            check({tag, "_held_valid"}, 32'(valid), 32'd1);
            check({tag, "_held_resp"}, 32'(resp), 32'(prev_resp));
        end
        start = 1'b1; challenge = ch; ro_a = va[0]; ro_b = vb[0];
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            start = (k == bsk);
            challenge = 6'($urandom);
            ro_a = va[k + 1]; ro_b = vb[k + 1];
            if (k == abort_k) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_valid"}, 32'(valid), 32'd0);
                check({tag, "_rst_resp"}, 32'(resp), 32'd0);
                check({tag, "_rst_tie"}, 32'(tie), 32'd0);
                check({tag, "_rst_sat"}, 32'(sat2), 32'd0);
                check({tag, "_rst_sel"}, 32'({sel_a, sel_b}), 32'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                prev_valid = 1'b0;
                return;
            end
            if (k < LAT) begin
                ea = (int'(ch[2:0]) + k / P) % 8;
                eb = (ea + off) % 8;
                check($sformatf("%s_sel_a_k%0d", tag, k), 32'(sel_a), 32'(ea));
                check($sformatf("%s_sel_b_k%0d", tag, k), 32'(sel_b), 32'(eb));
                check($sformatf("%s_busy_k%0d", tag, k), 32'({busy, valid}), 32'b10);
            end else begin
                check({tag, "_valid"}, 32'({busy, valid, busy2, valid2}), 32'b0101);
                check({tag, "_resp"}, 32'(resp), 32'(e_resp));
                check({tag, "_tie"}, 32'(tie), 32'(e_tie));
                check({tag, "_sat"}, 32'(sat), 32'(e_sat));
                check({tag, "_resp2"}, 32'(resp2), 32'(e_resp2));
                check({tag, "_tie2"}, 32'(tie2), 32'(e_tie2));
                check({tag, "_sat2"}, 32'(sat2), 32'(e_sat2));
            end
        end
        start = 1'b0;
        prev_valid = 1'b1;
        prev_resp = e_resp;
    endtask

    initial begin
        tbl[0] = '{6'b001_000, 4, 0, 0, 8, 0, 0, 4'b1111, 0, 1'b0, 1'b0, 9};
        tbl[1] = '{6'b001_000, 4, 0, 0, 4, 0, 0, 4'b0000, 4, 1'b0, 1'b0, -1};
        tbl[2] = '{6'b000_111, 8, 0, 0, 4, 0, 0, 4'b0000, 0, 1'b0, 1'b0, -1};
        tbl[3] = '{6'b001_000, 2, 0, 0, 0, 0, 0, 4'b1111, 0, 1'b0, 1'b1, -1};
        tbl[4] = '{6'b010_101, 0, 0, 0, 0, 0, 1, 4'b0000, 4, 1'b0, 1'b0, -1};

        #1 rst_n = 1'b0;
        #2;
        check("reset_busy_valid", 32'({busy, valid}), 32'd0);
        check("reset_resp_tie", 32'({resp, tie}), 32'd0);
        check("reset_sat_sel", 32'({sat, sel_a, sel_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            fill_periodic(tbl[t].pa, tbl[t].pha, tbl[t].la, tbl[t].pb, tbl[t].phb, tbl[t].lb);
            run_eval(tbl[t].ch, tbl[t].bsk, -1, 1'b1, tbl[t].resp, tbl[t].tie,
                     tbl[t].sat1, tbl[t].sat2, $sformatf("vec%0d", t));
        end

        fill_periodic(4, 0, 0, 8, 0, 0);
        run_eval(6'b001_000, -1, 19, 1'b1, 4'b1111, 0, 1'b0, 1'b0, "abort");
        run_eval(6'b001_000, -1, -1, 1'b1, 4'b1111, 0, 1'b0, 1'b0, "fresh");

        for (int n = 0; n < 20; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                for (int i = 0; i < 64; i++) begin
                    va[i] = 1'($urandom_range(0, 1));
                    vb[i] = 1'($urandom_range(0, 1));
                end
            end else begin
                fill_periodic(2 * int'($urandom_range(1, 6)), int'($urandom_range(0, 11)), int'($urandom_range(0, 1)),
                              2 * int'($urandom_range(0, 6)), int'($urandom_range(0, 11)), int'($urandom_range(0, 1)));
            end
            run_eval(6'($urandom), (n % 3 == 0) ? int'($urandom_range(0, LAT - 2)) : -1, -1,
                     1'b0, '0, 0, 1'b0, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
